// File: rtl/i2c_slave_ctrl_if.sv
// I2C slave controller bus bundle: bit-unit handshakes, bus events and the
// byte-level user interface.
interface i2c_slave_ctrl_if;
  // read (receiver) unit
  logic       rd_en;
  logic       rd_is_byte;
  logic       rd_ld;
  logic       rd_data;
  logic       rd_finish;
  // bus condition detectors
  logic       get_start;
  logic       get_stop;
  logic       bus_err;
  // write (transmitter) unit
  logic       wr_en;
  logic       wr_is_byte;
  logic       wr_ld;
  logic       wr_data;
  logic       wr_finish;
  // user side
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       busy;
  logic       err;

  modport slave (
    output rd_en, rd_is_byte, wr_en, wr_is_byte, wr_data,
           rx_data, rx_valid, tx_req, busy, err,
    input  rd_ld, rd_data, rd_finish, get_start, get_stop, bus_err,
           wr_ld, wr_finish, tx_data
  );

  modport master (
    input  rd_en, rd_is_byte, wr_en, wr_is_byte, wr_data,
           rx_data, rx_valid, tx_req, busy, err,
    output rd_ld, rd_data, rd_finish, get_start, get_stop, bus_err,
           wr_ld, wr_finish, tx_data
  );
endinterface

// File: rtl/i2c_slave_ctrl.sv
// I2C slave transaction sequencer. Drives the bit-level read/write units,
// shifts bytes through a single shift register, decides ACK/NACK and
// presents a byte-level user interface.
// Optional feature macro: I2C_GENERAL_CALL_EN (also ACK general call 8'h00).
module i2c_slave_ctrl #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input logic            clk,
  input logic            rst_n,
  i2c_slave_ctrl_if.slave bus
);

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_RX_BYTE,
    S_RX_ACK,
    S_TX_LOAD,
    S_TX_BYTE,
    S_TX_ACK,
    S_WAIT_STOP
  } state_e;

  state_e              state_q, state_d;
  logic [BYTE_W-1:0]   sr_q, sr_d;
  logic [BYTE_W-1:0]   sr_shift;
  logic                dir_q, dir_d;
  logic                addr_match;
  logic                rd_en_q, rd_en_d;
  logic                rd_is_byte_q, rd_is_byte_d;
  logic                wr_en_q, wr_en_d;
  logic                wr_is_byte_q, wr_is_byte_d;
  logic [BYTE_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                tx_req_q, tx_req_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  // Shift register view including a bit strobed in this very cycle
  always_comb begin
    sr_shift = sr_q;
    if (bus.rd_ld) sr_shift = {sr_q[BYTE_W-2:0], bus.rd_data};
  end

  // Address decode on the (possibly just completed) address byte
  always_comb begin
`ifdef I2C_GENERAL_CALL_EN
    addr_match = (sr_shift[BYTE_W-1:1] == SLAVE_ADDR) || (sr_shift == 8'h00);
`else
    addr_match = (sr_shift[BYTE_W-1:1] == SLAVE_ADDR);
`endif
  end

  // Next-state, shift register and registered-output computation
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_shift;
    dir_d      = dir_q;
    err_d      = err_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;

    if (bus.wr_ld) sr_d = {sr_shift[BYTE_W-2:0], 1'b0};

    if (bus.bus_err) begin
      err_d   = 1'b1;
      state_d = S_WAIT_STOP;
    end else if (bus.get_stop) begin
      state_d = S_IDLE;
    end else if (bus.get_start) begin
      // partial byte from an interrupted transfer is discarded
      state_d = S_ADDR;
      err_d   = 1'b0;
      sr_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_ADDR: begin
          if (bus.rd_finish) begin
            if (addr_match) begin
              state_d = S_ADDR_ACK;
              dir_d   = sr_shift[0];
              sr_d    = '0;         // ACK bit is sr[7] = 0
            end else begin
              state_d = S_WAIT_STOP;
            end
          end
        end
        S_ADDR_ACK: if (bus.wr_finish) state_d = dir_q ? S_TX_LOAD : S_RX_BYTE;
        S_RX_BYTE: begin
          if (bus.rd_finish) begin
            rx_data_d  = sr_shift;
            rx_valid_d = 1'b1;
            state_d    = S_RX_ACK;
            sr_d       = '0;
          end
        end
        S_RX_ACK: if (bus.wr_finish) state_d = S_RX_BYTE;
        S_TX_LOAD: begin
          // first cycle raises tx_req, second cycle samples tx_data
          if (!tx_req_q) begin
            sr_d    = bus.tx_data;
            state_d = S_TX_BYTE;
          end
        end
        S_TX_BYTE: if (bus.wr_finish) state_d = S_TX_ACK;
        S_TX_ACK: begin
          if (bus.rd_finish) state_d = sr_shift[0] ? S_WAIT_STOP : S_TX_LOAD;
        end
        S_WAIT_STOP: ;
        default: state_d = S_IDLE;
      endcase
    end

    tx_req_d     = (state_d == S_TX_LOAD) && (state_q != S_TX_LOAD);
    rd_en_d      = (state_d == S_ADDR) || (state_d == S_RX_BYTE) || (state_d == S_TX_ACK);
    rd_is_byte_d = (state_d == S_ADDR) || (state_d == S_RX_BYTE);
    wr_en_d      = (state_d == S_ADDR_ACK) || (state_d == S_RX_ACK) || (state_d == S_TX_BYTE);
    wr_is_byte_d = (state_d == S_TX_BYTE);
    busy_d       = (state_d == S_ADDR_ACK) || (state_d == S_RX_BYTE) ||
                   (state_d == S_RX_ACK)   || (state_d == S_TX_LOAD) ||
                   (state_d == S_TX_BYTE)  || (state_d == S_TX_ACK);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sr_q         <= '0;
      dir_q        <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_is_byte_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_is_byte_q <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      tx_req_q     <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      dir_q        <= dir_d;
      rd_en_q      <= rd_en_d;
      rd_is_byte_q <= rd_is_byte_d;
      wr_en_q      <= wr_en_d;
      wr_is_byte_q <= wr_is_byte_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      tx_req_q     <= tx_req_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign bus.rd_en      = rd_en_q;
  assign bus.rd_is_byte = rd_is_byte_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_is_byte = wr_is_byte_q;
  assign bus.wr_data    = sr_q[BYTE_W-1];
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.tx_req     = tx_req_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Directed self-checking bench for i2c_slave_ctrl. Models the read/write bit
// units and the user side; honours I2C_GENERAL_CALL_EN when defined.
module tb_i2c_slave_ctrl;

`ifdef I2C_GENERAL_CALL_EN
  localparam bit GC = 1'b1;
`else
  localparam bit GC = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  // running event counters sampled on the falling edge
  int rx_cnt    = 0;
  int txreq_cnt = 0;
  int wren_cnt  = 0;
  int both_cnt  = 0;

  i2c_slave_ctrl_if bus ();

  i2c_slave_ctrl #(.SLAVE_ADDR(7'h50)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // event monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rx_valid) rx_cnt++;
      if (bus.tx_req) txreq_cnt++;
      if (bus.wr_en) wren_cnt++;
      if (bus.wr_en && bus.rd_en) both_cnt++;
    end
  end

  // read unit model: wait for rd_en, deliver n bits MSB first, optionally finish
  task automatic rd_unit(input logic [7:0] bits, input int n, input bit finish,
                         output bit ok, output bit is_byte);
    logic [7:0] b;
    b       = bits;
    ok      = 1'b0;
    is_byte = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.rd_en) begin
        ok      = 1'b1;
        is_byte = bus.rd_is_byte;
      end
    end
    if (ok) begin
      for (int k = 0; k < n; k++) begin
        bus.rd_ld   = 1'b1;
        bus.rd_data = b[3'(n-1-k)];
        @(negedge clk);
      end
      bus.rd_ld = 1'b0;
      if (finish) begin
        bus.rd_finish = 1'b1;
        @(negedge clk);
        bus.rd_finish = 1'b0;
      end
    end
  endtask

  // write unit model: wait for wr_en, capture n bits, finish
  task automatic wr_unit(input int n, input int timeout, output logic [7:0] bits,
                         output bit ok, output bit is_byte);
    ok      = 1'b0;
    is_byte = 1'b0;
    bits    = 8'h00;
    for (int i = 0; i < timeout && !ok; i++) begin
      @(negedge clk);
      if (bus.wr_en) begin
        ok      = 1'b1;
        is_byte = bus.wr_is_byte;
      end
    end
    if (ok) begin
      for (int k = 0; k < n; k++) begin
        bits       = {bits[6:0], bus.wr_data};
        bus.wr_ld  = 1'b1;
        @(negedge clk);
        bus.wr_ld  = 1'b0;
      end
      bus.wr_finish = 1'b1;
      @(negedge clk);
      bus.wr_finish = 1'b0;
    end
  endtask

  task automatic pulse_start();
    bus.get_start = 1'b1;
    @(negedge clk);
    bus.get_start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.get_stop = 1'b1;
    @(negedge clk);
    bus.get_stop = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [16:0] obs;
    @(negedge clk);
    obs = {bus.rd_en, bus.rd_is_byte, bus.wr_en, bus.wr_is_byte, bus.wr_data,
           bus.rx_valid, bus.tx_req, bus.busy, bus.err, bus.rx_data};
    n_checks++;
    if (obs !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 00000", obs);
    end
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.rd_en !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: rd_en=%b busy=%b want 0 0", bus.rd_en, bus.busy);
    end
  endtask

  task automatic test_write();
    bit ok, isb;
    logic [7:0] bits;
    int rx0;
    rx0 = rx_cnt;
    pulse_start();
    rd_unit(8'hA0, 8, 1'b1, ok, isb);
    n_checks++;
    if (ok !== 1'b1 || isb !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_addr_read: ok=%b is_byte=%b want 1 1", ok, isb);
    end
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_busy: got %b want 1", bus.busy);
    end
    wr_unit(1, 6, bits, ok, isb);
    n_checks++;
    if (ok !== 1'b1 || bits[0] !== 1'b0 || isb !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_addr_ack: ok=%b bit=%b is_byte=%b want 1 0 0", ok, bits[0], isb);
    end
    rd_unit(8'h3C, 8, 1'b1, ok, isb);
    wr_unit(1, 6, bits, ok, isb);
    n_checks++;
    if (ok !== 1'b1 || bits[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_data_ack: ok=%b bit=%b want 1 0", ok, bits[0]);
    end
    n_checks++;
    if (bus.rx_data !== 8'h3C || (rx_cnt - rx0) !== 1) begin
      n_fail++;
      $display("FAIL wr_rx_data: data=%h pulses=%0d want 3c 1", bus.rx_data, rx_cnt - rx0);
    end
    pulse_stop();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.rd_en !== 1'b0 || bus.wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_after_stop: busy=%b rd_en=%b wr_en=%b want 0 0 0",
               bus.busy, bus.rd_en, bus.wr_en);
    end
  endtask

  task automatic test_read();
    bit ok, isb;
    logic [7:0] bits;
    int tq0;
    tq0 = txreq_cnt;
    bus.tx_data = 8'h96;
    pulse_start();
    rd_unit(8'hA1, 8, 1'b1, ok, isb);
    wr_unit(1, 6, bits, ok, isb);
    n_checks++;
    if (ok !== 1'b1 || bits[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_addr_ack: ok=%b bit=%b want 1 0", ok, bits[0]);
    end
    wr_unit(8, 10, bits, ok, isb);
    n_checks++;
    if (ok !== 1'b1 || bits !== 8'h96 || isb !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_byte0: ok=%b bits=%h is_byte=%b want 1 96 1", ok, bits, isb);
    end
    bus.tx_data = 8'h5A;
    rd_unit(8'h00, 1, 1'b1, ok, isb);
    n_checks++;
    if (ok !== 1'b1 || isb !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_master_ack: ok=%b is_byte=%b want 1 0", ok, isb);
    end
    wr_unit(8, 10, bits, ok, isb);
    n_checks++;
    if (ok !== 1'b1 || bits !== 8'h5A) begin
      n_fail++;
      $display("FAIL rd_byte1: ok=%b bits=%h want 1 5a", ok, bits);
    end
    rd_unit(8'h01, 1, 1'b1, ok, isb);
    @(negedge clk);
    n_checks++;
    if ((txreq_cnt - tq0) !== 2) begin
      n_fail++;
      $display("FAIL rd_txreq_count: got %0d want 2", txreq_cnt - tq0);
    end
    n_checks++;
    if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0 || bus.rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_wait_stop: busy=%b wr_en=%b rd_en=%b want 0 0 0",
               bus.busy, bus.wr_en, bus.rd_en);
    end
    pulse_stop();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.tx_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_after_stop: busy=%b tx_req=%b want 0 0", bus.busy, bus.tx_req);
    end
  endtask

  task automatic test_no_ack();
    bit ok, isb;
    logic [7:0] bits;
    int rx0, we0;
    rx0 = rx_cnt;
    we0 = wren_cnt;
    pulse_start();
    rd_unit(8'hB0, 8, 1'b1, ok, isb);
    wr_unit(1, 6, bits, ok, isb);
    n_checks++;
    if (ok !== 1'b0 || (wren_cnt - we0) !== 0) begin
      n_fail++;
      $display("FAIL noack_wr_en: ok=%b wr_en_cycles=%0d want 0 0", ok, wren_cnt - we0);
    end
    n_checks++;
    if (bus.busy !== 1'b0 || (rx_cnt - rx0) !== 0) begin
      n_fail++;
      $display("FAIL noack_busy_rx: busy=%b rx=%0d want 0 0", bus.busy, rx_cnt - rx0);
    end
    pulse_stop();
  endtask

  task automatic test_bus_err();
    bit ok, isb;
    logic [7:0] bits;
    int rx0;
    rx0 = rx_cnt;
    pulse_start();
    rd_unit(8'hA0, 8, 1'b1, ok, isb);
    wr_unit(1, 6, bits, ok, isb);
    rd_unit(8'h05, 3, 1'b0, ok, isb);
    bus.bus_err = 1'b1;
    @(negedge clk);
    bus.bus_err = 1'b0;
    n_checks++;
    if (bus.err !== 1'b1 || bus.rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL berr_response: err=%b rd_en=%b want 1 0", bus.err, bus.rd_en);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.err !== 1'b1 || (rx_cnt - rx0) !== 0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL berr_sticky: err=%b rx=%0d busy=%b want 1 0 0",
               bus.err, rx_cnt - rx0, bus.busy);
    end
    pulse_start();
    n_checks++;
    if (bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL berr_clear: err=%b want 0", bus.err);
    end
    pulse_stop();
  endtask

  task automatic test_repeated_start();
    bit ok, isb;
    logic [7:0] bits;
    int rx0;
    rx0 = rx_cnt;
    pulse_start();
    rd_unit(8'hA0, 8, 1'b1, ok, isb);
    wr_unit(1, 6, bits, ok, isb);
    rd_unit(8'h0A, 4, 1'b0, ok, isb);
    pulse_start();
    rd_unit(8'hA0, 8, 1'b1, ok, isb);
    wr_unit(1, 6, bits, ok, isb);
    n_checks++;
    if (ok !== 1'b1 || bits[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rs_addr_ack: ok=%b bit=%b want 1 0", ok, bits[0]);
    end
    rd_unit(8'hFF, 8, 1'b1, ok, isb);
    wr_unit(1, 6, bits, ok, isb);
    n_checks++;
    if ((rx_cnt - rx0) !== 1 || bus.rx_data !== 8'hFF) begin
      n_fail++;
      $display("FAIL rs_rx: pulses=%0d data=%h want 1 ff", rx_cnt - rx0, bus.rx_data);
    end
    pulse_stop();
  endtask

  task automatic test_general_call();
    bit ok, isb;
    logic [7:0] bits;
    int rx0;
    rx0 = rx_cnt;
    pulse_start();
    rd_unit(8'h00, 8, 1'b1, ok, isb);
    wr_unit(1, 6, bits, ok, isb);
    n_checks++;
    if (ok !== GC) begin
      n_fail++;
      $display("FAIL gc_addr_ack: ok=%b want %b", ok, GC);
    end
    rd_unit(8'h55, 8, 1'b1, ok, isb);
    wr_unit(1, 6, bits, ok, isb);
    n_checks++;
    if ((rx_cnt - rx0) !== int'(GC) || (GC && bus.rx_data !== 8'h55)) begin
      n_fail++;
      $display("FAIL gc_rx: pulses=%0d data=%h want %0d 55", rx_cnt - rx0, bus.rx_data, GC);
    end
    pulse_stop();
    pulse_start();
    rd_unit(8'h01, 8, 1'b1, ok, isb);
    wr_unit(1, 6, bits, ok, isb);
    n_checks++;
    if (ok !== 1'b0) begin
      n_fail++;
      $display("FAIL gc_read_nack: ok=%b want 0", ok);
    end
    pulse_stop();
  endtask

  task automatic test_reset_mid();
    bit ok, isb;
    logic [7:0] bits;
    pulse_start();
    rd_unit(8'hA0, 8, 1'b1, ok, isb);
    wr_unit(1, 6, bits, ok, isb);
    n_checks++;
    if (bus.rd_en !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: rd_en=%b busy=%b want 1 1", bus.rd_en, bus.busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.rd_en !== 1'b0 || bus.busy !== 1'b0 || bus.wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: rd_en=%b busy=%b wr_en=%b want 0 0 0",
               bus.rd_en, bus.busy, bus.wr_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.rd_en !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_idle: rd_en=%b busy=%b want 0 0", bus.rd_en, bus.busy);
    end
  endtask

  initial begin
    rst_n         = 1'b1;
    bus.rd_ld     = 1'b0;
    bus.rd_data   = 1'b0;
    bus.rd_finish = 1'b0;
    bus.get_start = 1'b0;
    bus.get_stop  = 1'b0;
    bus.bus_err   = 1'b0;
    bus.wr_ld     = 1'b0;
    bus.wr_finish = 1'b0;
    bus.tx_data   = 8'h00;
    #1 rst_n = 1'b0;

    test_reset();
    test_write();
    test_read();
    test_no_ack();
    test_bus_err();
    test_repeated_start();
    test_general_call();
    test_reset_mid();

    n_checks++;
    if (both_cnt !== 0) begin
      n_fail++;
      $display("FAIL both_enables: cycles=%0d want 0", both_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_slave_ctrl.md
Name: i2c_slave_ctrl

Overview:
- Transaction sequencer for the I2C slave datapath.
- Owns the bit/byte units I2C_slave_read (receiver) and I2C_slave_write (transmitter). Enables each unit in turn, packs and unpacks bytes, decides ACK/NACK, and exposes a byte-level user interface.
- Sits between the slave bit units and the register file / user logic.

Parameters:
- SLAVE_ADDR, 7'h50: 7-bit address this slave answers to.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- rd_en  output  1  enable to read unit; held until rd_finish
- rd_is_byte  output  1  1 = read unit receives 8 bits, 0 = 1 bit
- rd_ld  input  1  read unit strobe: rd_data valid this cycle
- rd_data  input  1  received bit
- rd_finish  input  1  read unit done
- get_start  input  1  START or repeated START detected
- get_stop  input  1  STOP detected
- bus_err  input  1  SDA changed while SCL high inside a bit
- wr_en  output  1  enable to write unit; held until wr_finish
- wr_is_byte  output  1  1 = write unit sends 8 bits, 0 = 1 bit
- wr_ld  input  1  write unit strobe: consumes wr_data this cycle
- wr_data  output  1  bit to transmit
- wr_finish  input  1  write unit done
- rx_data  output  8  last received data byte
- rx_valid  output  1  1-cycle pulse: rx_data updated
- tx_req  output  1  1-cycle pulse: user must present tx_data next cycle
- tx_data  input  8  byte to transmit, sampled 1 cycle after tx_req
- busy  output  1  addressed transaction in progress
- err  output  1  sticky bus error; cleared on next get_start

Behaviour:
- Reset values: all outputs 0; state IDLE; shift register 8'h00.
- Sub-unit handshake:
  - Ctrl raises rd_en/wr_en on state entry and keeps it high.
  - On the first cycle rd_finish/wr_finish is seen, the state advances and the enable drops on the next clock edge.
  - Never both enables high.
- Shift register:
  - On rd_ld: sr <= {sr[6:0], rd_data}.
  - wr_data = sr[7]; on wr_ld: sr <= {sr[6:0], 1'b0}.
- FSM:
  - IDLE: wait get_start -> ADDR.
  - ADDR: read byte.
    - If sr[7:1]==SLAVE_ADDR -> ADDR_ACK; latch dir = sr[0].
    - Otherwise -> WAIT_STOP (no ACK driven).
  - ADDR_ACK: write bit 0.
    - dir=0 -> RX_BYTE.
    - dir=1 -> TX_LOAD.
  - RX_BYTE: read byte; rx_data <= sr, rx_valid pulse same edge as transition -> RX_ACK.
  - RX_ACK: write bit 0 -> RX_BYTE.
  - TX_LOAD: tx_req pulse on entry; next cycle sr <= tx_data -> TX_BYTE.
  - TX_BYTE: write byte (MSB first) -> TX_ACK.
  - TX_ACK: read bit.
    - rd_data==0 (ACK) -> TX_LOAD.
    - rd_data==1 (NACK) -> WAIT_STOP.
  - WAIT_STOP: enables low; wait get_start/get_stop.
- Priority each cycle, from any state:
  1. bus_err -> err=1, enables dropped, WAIT_STOP.
  2. get_stop -> IDLE.
  3. get_start -> ADDR, err cleared.
  4. Normal FSM step.
- Repeated START mid-byte: the partial byte is discarded, no rx_valid.
- busy = 1 in ADDR_ACK through TX_ACK; 0 in IDLE, ADDR and WAIT_STOP.
- Reset mid-transaction: immediate return to IDLE with all outputs 0.

Optional Feature:
- I2C_GENERAL_CALL_EN defined: ADDR state also ACKs byte 8'h00 (general call, write), then proceeds as dir=0. Address 8'h01 is still not ACKed.
- Undefined: only SLAVE_ADDR is matched; 8'h00 -> WAIT_STOP.

Test Plan:
- START, addr 0xA0 (0x50 write), data 0x3C, STOP -> ACK driven for both bytes; rx_data=0x3C with one rx_valid pulse; busy falls; state IDLE.
- START, addr 0xA1, user tx_data 0x96 then 0x5A, master ACK then NACK -> SDA bits 10010110 then 01011010; exactly 2 tx_req pulses; WAIT_STOP; IDLE after STOP.
- START, addr 0xB0 -> no ACK (wr_en never high), busy stays 0, no rx_valid until next START.
- Inject bus_err during data bit 3 of write byte -> err=1, rd_en low next cycle, no rx_valid; next START clears err.
- Repeated START after 4 data bits, then addr 0xA0, data 0xFF -> one rx_valid with 0xFF only.
- With I2C_GENERAL_CALL_EN: addr 0x00 -> ACK and data received. Without it: no ACK.
